// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding and 8N1 frame constants.
// The matching receiver imports the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // 40 MHz system clock at 9600 baud
  localparam int DEFAULT_CLKS_PER_BIT = 4167;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;  // start + 8 data + stop
  localparam int BIT_IDX_W  = $clog2(DATA_BITS);

  // Clock cycles occupied by one complete frame on the line
  function automatic int frame_cycles(input int clks_per_bit);
    return FRAME_BITS * clks_per_bit;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with synchronous flush. Occupancy flags come straight from
// the registered count, so a full FIFO refuses a push even while a pop is
// happening in the same cycle. The next-state count is exported so the
// owner can register status flags in step with the FIFO.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DATA_BITS-1:0]       data_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  output logic [DATA_BITS-1:0]       data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_d_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q,  count_d;
  logic                 push_ok;
  logic                 pop_ok;

  assign full_o   = (count_q == CNT_W'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign data_o   = mem_q[rd_ptr_q];
  assign count_d_o = count_d;

  // A flush discards any push or pop offered in the same cycle
  assign push_ok = push_i & ~full_o  & ~clear_i;
  assign pop_ok  = pop_i  & ~empty_o & ~clear_i;

  // Next-state pointers and occupancy; pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // Pointer and count registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the pointers do
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a byte FIFO. Bytes are taken from the FIFO
// only while idle, shifted out LSB-first, and each frame ends with a
// one-cycle tx_done pulse in the cycle after the stop bit.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 tx_done,
  input  logic                 clear
);

  localparam int                   FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_IDX_W-1:0] BIT_LAST = BIT_IDX_W'(DATA_BITS - 1);

  uart_state_e            state_q,   state_d;
  logic [CNT_W-1:0]       cnt_q,     cnt_d;
  logic [BIT_IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q,   shift_d;
  logic                   tx_q,      tx_d;
  logic                   done_q,    done_d;
  logic                   busy_q,    busy_d;

  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_rd_data;
  logic [FCNT_W-1:0]      fifo_count_d;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push_i    (in_valid),
    .data_i    (in_data),
    .pop_i     (fifo_pop),
    .clear_i   (clear),
    .data_o    (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_d_o (fifo_count_d)
  );

  assign in_ready = ~fifo_full;
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign busy     = busy_q;

  // Serialiser next-state: the line level is computed one cycle ahead so
  // that tx comes straight from a flop
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    done_d    = 1'b0;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d  = 1'b1;
        cnt_d = '0;
        // A flush in the same cycle wins over starting a new frame
        if (!fifo_empty && !clear) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rd_data;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + BIT_IDX_W'(1);
            tx_d      = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d != IDLE) | (fifo_count_d != '0);
  end

  // Serialiser state register; reset aborts any frame and idles the line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: a byte-queue model of the FIFO plus a
// bit-timed line receiver decode every frame and check flags each cycle.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       clear = 1'b0;
  logic       in_ready, tx, busy, fifo_full, fifo_empty, tx_done;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH),
    .CNT_W        (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .tx_done    (tx_done),
    .clear      (clear)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model and monitor ----------------
  logic [7:0] model_q[$];
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         prev_rst_low = 1'b0;
  bit         prev_push = 1'b0;
  bit         prev_clear = 1'b0;
  logic [7:0] prev_data = 8'h00;
  bit         rx_active = 1'b0;
  int         rx_cyc = 0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_exp = 8'h00;
  int         exp_start = -1;
  int         frames = 0;

  always @(negedge clk) begin
    bit start_now;
    bit end_now;
    cyc++;
    start_now = 1'b0;
    end_now   = 1'b0;
    if (prev_rst_low) begin
      mon_en    = 1'b1;
      model_q.delete();
      rx_active = 1'b0;
      exp_start = -1;
    end else if (mon_en) begin
      if (rx_active) begin
        rx_cyc++;
        if (rx_cyc == CPB / 2)
          chk("start_bit", 32'(tx), 32'(1'b0));
        else if (rx_cyc > CPB && rx_cyc < 9 * CPB && (rx_cyc % CPB) == CPB / 2)
          rx_byte = {tx, rx_byte[7:1]};
        else if (rx_cyc == 9 * CPB + CPB / 2)
          chk("stop_bit", 32'(tx), 32'(1'b1));
        if (rx_cyc == FRAME) begin
          chk("rx_byte", 32'(rx_byte), 32'(rx_exp));
          $display("FRAME rx=%02h exp=%02h t=%0t", rx_byte, rx_exp, $time);
          frames++;
          rx_active = 1'b0;
          end_now   = 1'b1;
          if (model_q.size() != 0) exp_start = cyc + 1;
        end
      end else if (tx === 1'b0) begin
        chk("queued_byte_at_start", 32'(model_q.size() > 0), 32'(1));
        if (model_q.size() > 0) begin
          rx_exp    = model_q.pop_front();
          rx_active = 1'b1;
          rx_cyc    = 0;
          start_now = 1'b1;
        end
      end
      if (exp_start == cyc) begin
        chk("start_latency", 32'(start_now), 32'(!prev_clear));
        exp_start = -1;
      end
      if (prev_clear) model_q.delete();
      if (prev_push) begin
        if (!rx_active && model_q.size() == 0) exp_start = cyc + 1;
        model_q.push_back(prev_data);
      end
      chk("depth_bound", 32'(model_q.size() <= DEPTH), 32'(1));
    end
    if (mon_en) begin
      chk("tx_done",    32'(tx_done),    32'(end_now));
      chk("in_ready",   32'(in_ready),   32'(model_q.size() < DEPTH));
      chk("fifo_full",  32'(fifo_full),  32'(model_q.size() == DEPTH));
      chk("fifo_empty", 32'(fifo_empty), 32'(model_q.size() == 0));
      chk("busy",       32'(busy),       32'(rx_active || model_q.size() != 0));
      if (prev_rst_low) chk("tx_in_reset", 32'(tx), 32'(1'b1));
    end
    prev_rst_low = !rst_n;
    prev_clear   = clear && rst_n;
    prev_push    = in_valid && (in_ready === 1'b1) && !clear && rst_n;
    prev_data    = in_data;
  end

  // ---------------- stimulus ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    int waited;
    bit ok;
    waited = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    while (!ok && waited < 1000) begin
      @(negedge clk);
      ok = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'(1));
    $display("PUSH %02h after %0d cycles", b, waited);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy !== 1'b0 && n < 3000);
    chk("idle_reached", 32'(busy), 32'(1'b0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    int f0;
    logic [7:0] fill_bytes[5];
    fill_bytes = '{8'h0F, 8'h11, 8'h22, 8'h33, 8'h44};

    // reset with a byte offered: nothing may be accepted
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hAA;
    wait_cyc(3);
    in_valid = 1'b0;
    rst_n = 1'b1;
    wait_cyc(2);
    chk("empty_after_reset", 32'(fifo_empty), 32'(1'b1));

    // single byte
    f0 = frames;
    push(8'h3D);
    wait_idle();
    chk("single_frames", 32'(frames - f0), 32'(1));

    // fill, then one more push that must wait for a pop
    f0 = frames;
    foreach (fill_bytes[i]) push(fill_bytes[i]);
    @(negedge clk);
    chk("full_after_fill", 32'(fifo_full), 32'(1'b1));
    chk("ready_low_when_full", 32'(in_ready), 32'(1'b0));
    @(posedge clk);
    #1;
    push(8'h55);
    wait_idle();
    chk("fill_frames", 32'(frames - f0), 32'(6));

    // flush mid-frame with a push offered in the same cycle
    f0 = frames;
    push(8'h5A);
    push(8'h66);
    push(8'h77);
    push(8'h88);
    wait_cyc(50);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h99;
    wait_cyc(1);
    clear = 1'b0;
    in_valid = 1'b0;
    wait_idle();
    chk("clear_frames", 32'(frames - f0), 32'(1));

    // reset during data bit 4
    f0 = frames;
    push(8'hA5);
    wait_cyc(86);
    rst_n = 1'b0;
    wait_cyc(1);
    rst_n = 1'b1;
    wait_cyc(200);
    chk("abort_frames", 32'(frames - f0), 32'(0));
    push(8'hC3);
    wait_idle();
    chk("after_abort_frames", 32'(frames - f0), 32'(1));

    // randomized traffic with occasional flushes
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        clear = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        in_data = 8'($urandom);
        wait_cyc(1);
        clear = 1'b0;
        in_valid = 1'b0;
      end else if (r < 7) begin
        push(8'($urandom));
      end else begin
        wait_cyc(int'($urandom_range(1, 200)));
      end
    end
    wait_idle();
    chk("model_drained", 32'(model_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
